// File: rtl/model_matrix_pkg.sv
// Shared definitions for the NTM algebra matrix streaming blocks.
//   - model_matrix_state_t : four-state sequencing used by transmit/receive sides
//   - ZERO_/ONE_ DATA and CONTROL constants
//   - index_width()        : counter/index width for a dimension (never below 1)
package model_matrix_pkg;

   typedef enum logic [1:0] {
      STARTER_STATE        = 2'd0,
      MATRIX_INITIAL_STATE = 2'd1,
      MATRIX_OUTPUT_STATE  = 2'd2,
      DONE_STATE           = 2'd3
   } model_matrix_state_t;

   localparam int ZERO_DATA    = 0;
   localparam int ONE_DATA     = 1;
   localparam int ZERO_CONTROL = 0;
   localparam int ONE_CONTROL  = 1;

   // A dimension of 1 still needs a 1-bit index so port widths stay legal.
   function automatic int index_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/model_matrix_stream_transmitter_if.sv
// Bus bundle of the matrix stream transmitter.
//   master : the transmitter (drives ready/size_error/data_out*, receives the rest)
//   slave  : whoever loads the buffer, starts a run and consumes the stream
// Signals: start, ready, size_error, write_enable, write_index_i, write_index_j,
//          write_data, size_i_in, size_j_in, data_out_i_enable, data_out_j_enable, data_out
interface model_matrix_stream_transmitter_if #(
   parameter int DATA_SIZE = 64,
   parameter int SIZE_I    = 4,
   parameter int SIZE_J    = 4
) ();
   import model_matrix_pkg::*;

   localparam int IDX_I_W = index_width(SIZE_I);
   localparam int IDX_J_W = index_width(SIZE_J);

   logic                 start;
   logic                 ready;
   logic                 size_error;
   logic                 write_enable;
   logic [IDX_I_W-1:0]   write_index_i;
   logic [IDX_J_W-1:0]   write_index_j;
   logic [DATA_SIZE-1:0] write_data;
   logic [DATA_SIZE-1:0] size_i_in;
   logic [DATA_SIZE-1:0] size_j_in;
   logic                 data_out_i_enable;
   logic                 data_out_j_enable;
   logic [DATA_SIZE-1:0] data_out;

   modport master (
      input  start, write_enable, write_index_i, write_index_j, write_data,
             size_i_in, size_j_in,
      output ready, size_error, data_out_i_enable, data_out_j_enable, data_out
   );

   modport slave (
      output start, write_enable, write_index_i, write_index_j, write_data,
             size_i_in, size_j_in,
      input  ready, size_error, data_out_i_enable, data_out_j_enable, data_out
   );

endinterface

// File: rtl/model_matrix_index_counter.sv
// Row-major 2-D index counter shared by the matrix stream blocks.
//   CLK, RST        : clock, synchronous active-high reset
//   clear           : force i=j=0
//   enable          : advance one element (j first, then i)
//   last_i, last_j  : highest index to reach in each dimension (size-1)
//   index_i/index_j : current position
//   row_first       : current element is the first of its row
//   last            : current element is the final one; the counter holds there
module model_matrix_index_counter #(
   parameter int IDX_I_W = 2,
   parameter int IDX_J_W = 2,
   parameter int LIMIT_W = 64
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               clear,
   input  logic               enable,
   input  logic [LIMIT_W-1:0] last_i,
   input  logic [LIMIT_W-1:0] last_j,
   output logic [IDX_I_W-1:0] index_i,
   output logic [IDX_J_W-1:0] index_j,
   output logic               row_first,
   output logic               last
);

   logic [IDX_I_W-1:0] i_reg;
   logic [IDX_J_W-1:0] j_reg;
   logic               i_at_end;
   logic               j_at_end;

   // Limits are compared at full width so oversize limits never alias.
   assign i_at_end = (LIMIT_W'(i_reg) == last_i);
   assign j_at_end = (LIMIT_W'(j_reg) == last_j);

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         i_reg <= '0;
         j_reg <= '0;
      end else if (enable && !(i_at_end && j_at_end)) begin
         if (j_at_end) begin
            j_reg <= '0;
            i_reg <= i_reg + 1'b1;
         end else begin
            j_reg <= j_reg + 1'b1;
         end
      end
   end

   assign index_i   = i_reg;
   assign index_j   = j_reg;
   assign row_first = (j_reg == '0);
   assign last      = i_at_end && j_at_end;

endmodule

// File: rtl/model_matrix_stream_transmitter.sv
// Transmit side of the matrix streaming interface.
// Holds up to SIZE_I x SIZE_J words written at random; on start emits the
// requested size_i x size_j sub-matrix row-major, one element per clock.
//   CLK, RST : clock, synchronous active-high reset (buffer contents survive reset)
//   bus      : model_matrix_stream_transmitter_if.master (write port, start/sizes,
//              ready/size_error pulses, stream outputs)
module model_matrix_stream_transmitter
   import model_matrix_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4,
   parameter int SIZE_I       = 4,
   parameter int SIZE_J       = 4
) (
   input  logic CLK,
   input  logic RST,
   model_matrix_stream_transmitter_if.master bus
);

   localparam int IDX_I_W = index_width(SIZE_I);
   localparam int IDX_J_W = index_width(SIZE_J);
   localparam int DEPTH   = SIZE_I * SIZE_J;
   localparam int ADDR_W  = index_width(DEPTH);

   model_matrix_state_t  state_reg, state_next;
   logic [DATA_SIZE-1:0] size_i_reg, size_j_reg;
   logic                 ready_reg, ready_next;
   logic                 size_error_reg, size_error_next;
   logic                 i_enable_reg, i_enable_next;
   logic                 j_enable_reg, j_enable_next;
   logic [DATA_SIZE-1:0] data_out_reg;

   logic [DATA_SIZE-1:0] buffer_mem [DEPTH];
   logic                 write_accept;
   logic [ADDR_W-1:0]    write_addr, read_addr;

   logic [IDX_I_W-1:0]   cnt_i;
   logic [IDX_J_W-1:0]   cnt_j;
   logic                 cnt_row_first, cnt_last;
   logic                 size_illegal;

   function automatic logic [ADDR_W-1:0] flat_addr(input logic [IDX_I_W-1:0] i,
                                                   input logic [IDX_J_W-1:0] j);
      return ADDR_W'(i) * ADDR_W'(SIZE_J) + ADDR_W'(j);
   endfunction

   // Sizes are checked unsigned at full word width so a huge request whose
   // low bits look legal is still rejected.
   assign size_illegal = (size_i_reg == DATA_SIZE'(ZERO_DATA)) ||
                         (size_j_reg == DATA_SIZE'(ZERO_DATA)) ||
                         (size_i_reg >  DATA_SIZE'(SIZE_I))    ||
                         (size_j_reg >  DATA_SIZE'(SIZE_J));

   model_matrix_index_counter #(
      .IDX_I_W (IDX_I_W),
      .IDX_J_W (IDX_J_W),
      .LIMIT_W (DATA_SIZE)
   ) u_index_counter (
      .CLK       (CLK),
      .RST       (RST),
      .clear     (state_reg == MATRIX_INITIAL_STATE),
      .enable    (state_reg == MATRIX_OUTPUT_STATE),
      .last_i    (size_i_reg - DATA_SIZE'(ONE_DATA)),
      .last_j    (size_j_reg - DATA_SIZE'(ONE_DATA)),
      .index_i   (cnt_i),
      .index_j   (cnt_j),
      .row_first (cnt_row_first),
      .last      (cnt_last)
   );

   // Buffer only changes while idle, so a stream always sees a stable snapshot.
   assign write_accept = bus.write_enable && !RST && (state_reg == STARTER_STATE) &&
                         (32'(bus.write_index_i) < 32'(SIZE_I)) &&
                         (32'(bus.write_index_j) < 32'(SIZE_J));
   assign write_addr   = flat_addr(bus.write_index_i, bus.write_index_j);
   assign read_addr    = flat_addr(cnt_i, cnt_j);

   always_ff @(posedge CLK) begin
      if (write_accept) begin
         buffer_mem[write_addr] <= bus.write_data;
      end
   end

   // Registered read straight onto the output; holds between runs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         data_out_reg <= '0;
      end else if (state_reg == MATRIX_OUTPUT_STATE) begin
         data_out_reg <= buffer_mem[read_addr];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         size_i_reg <= '0;
         size_j_reg <= '0;
      end else if ((state_reg == STARTER_STATE) && bus.start) begin
         size_i_reg <= bus.size_i_in;
         size_j_reg <= bus.size_j_in;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= STARTER_STATE;
         ready_reg      <= 1'b0;
         size_error_reg <= 1'b0;
         i_enable_reg   <= 1'b0;
         j_enable_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ready_reg      <= ready_next;
         size_error_reg <= size_error_next;
         i_enable_reg   <= i_enable_next;
         j_enable_reg   <= j_enable_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      ready_next      = 1'b0;
      size_error_next = 1'b0;
      i_enable_next   = 1'b0;
      j_enable_next   = 1'b0;
      case (state_reg)
         STARTER_STATE: begin
            if (bus.start) begin
               state_next = MATRIX_INITIAL_STATE;
            end
         end
         MATRIX_INITIAL_STATE: begin
            state_next = size_illegal ? DONE_STATE : MATRIX_OUTPUT_STATE;
         end
         MATRIX_OUTPUT_STATE: begin
            j_enable_next = 1'b1;
            i_enable_next = cnt_row_first;
            if (cnt_last) begin
               state_next = DONE_STATE;
            end
         end
         DONE_STATE: begin
            ready_next      = 1'b1;
            size_error_next = size_illegal;
            state_next      = STARTER_STATE;
         end
         default: begin
            state_next = STARTER_STATE;
         end
      endcase
   end

   assign bus.ready             = ready_reg;
   assign bus.size_error        = size_error_reg;
   assign bus.data_out_i_enable = i_enable_reg;
   assign bus.data_out_j_enable = j_enable_reg;
   assign bus.data_out          = data_out_reg;

endmodule

// File: tb/tb_model_matrix_stream_transmitter.sv
// Self-checking bench for model_matrix_stream_transmitter (4x4 buffer, 64-bit words).
// A shadow copy of the buffer predicts every streamed element row-major.
module tb_model_matrix_stream_transmitter;

   localparam int DW = 64;
   localparam int SI = 4;
   localparam int SJ = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   model_matrix_stream_transmitter_if #(.DATA_SIZE(DW), .SIZE_I(SI), .SIZE_J(SJ)) bus ();

   model_matrix_stream_transmitter #(
      .DATA_SIZE    (DW),
      .CONTROL_SIZE (4),
      .SIZE_I       (SI),
      .SIZE_J       (SJ)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      logic [63:0] si;
      logic [63:0] sj;
      bit          err;
      int          n;
   } vec_t;

   logic [DW-1:0] mem [SI][SJ];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One idle-cycle write; the shadow copy follows only legal idle writes.
   task automatic write_word(input int i, input int j, input logic [DW-1:0] d);
      bus.write_enable  = 1'b1;
      bus.write_index_i = 2'(i);
      bus.write_index_j = 2'(j);
      bus.write_data    = d;
      mem[i][j]         = d;
      @(negedge CLK);
      bus.write_enable  = 1'b0;
   endtask

   // Runs one or more streams. mode 1: write [0][0] and pulse start mid-stream
   // (both must be ignored); mode 2: reset at the third element.
   task automatic run_stream(input logic [63:0] si, input logic [63:0] sj, input bit exp_err,
                             input int exp_n, input int mode, input int repeats, input string tag);
      int sjn;
      logic [DW-1:0] exp_d;
      sjn = int'(sj[31:0]);
      bus.start     = 1'b1;
      bus.size_i_in = si;
      bus.size_j_in = sj;
      for (int r = 0; r < repeats; r++) begin
         @(negedge CLK);
         bus.start        = 1'b0;
         bus.write_enable = 1'b0;
         bus.size_i_in    = {$urandom, $urandom};
         bus.size_j_in    = {$urandom, $urandom};
         @(negedge CLK);
         check($sformatf("%s r%0d pre", tag, r),
               {bus.ready, bus.data_out_j_enable, bus.data_out_i_enable}, 3'b000);
         if (exp_err) begin
            @(negedge CLK);
            check($sformatf("%s r%0d err", tag, r),
                  {bus.ready, bus.size_error, bus.data_out_i_enable, bus.data_out_j_enable}, 4'b1100);
         end else begin
            for (int k = 0; k < exp_n; k++) begin
               @(negedge CLK);
               bus.write_enable = 1'b0;
               bus.start        = 1'b0;
               exp_d = mem[k / sjn][k % sjn];
               check($sformatf("%s r%0d elem%0d", tag, r, k),
                     {bus.ready, bus.data_out_j_enable, bus.data_out_i_enable, bus.data_out},
                     {1'b0, 1'b1, (k % sjn) == 0, exp_d});
               if (k == 2 && mode == 1) begin
                  bus.write_enable  = 1'b1;
                  bus.write_index_i = 2'd0;
                  bus.write_index_j = 2'd0;
                  bus.write_data    = 64'h99;
                  bus.start         = 1'b1;
                  bus.size_i_in     = 64'd1;
                  bus.size_j_in     = 64'd1;
               end
               if (k == 2 && mode == 2) begin
                  RST = 1'b1;
                  @(negedge CLK);
                  RST = 1'b0;
                  check($sformatf("%s rst outputs", tag),
                        {bus.ready, bus.size_error, bus.data_out_i_enable, bus.data_out_j_enable, bus.data_out},
                        '0);
                  repeat (4) @(negedge CLK);
                  check($sformatf("%s rst no ready", tag),
                        {bus.ready, bus.data_out_j_enable}, 2'b00);
                  return;
               end
            end
            @(negedge CLK);
            bus.write_enable = 1'b0;
            bus.start        = 1'b0;
            check($sformatf("%s r%0d ready", tag, r),
                  {bus.ready, bus.size_error, bus.data_out_i_enable, bus.data_out_j_enable}, 4'b1000);
         end
         if (r + 1 < repeats) begin
            bus.start     = 1'b1;
            bus.size_i_in = si;
            bus.size_j_in = sj;
         end
      end
      @(negedge CLK);
      bus.start = 1'b0;
      check($sformatf("%s idle", tag),
            {bus.ready, bus.size_error, bus.data_out_i_enable, bus.data_out_j_enable}, 4'b0000);
   endtask

   initial begin
      vec_t vecs [9];
      logic [63:0] rsi, rsj;
      bit rerr;

      vecs[0] = '{64'd2, 64'd3, 1'b0, 6};
      vecs[1] = '{64'd0, 64'd3, 1'b1, 0};
      vecs[2] = '{64'd5, 64'd1, 1'b1, 0};
      vecs[3] = '{64'd3, 64'd0, 1'b1, 0};
      vecs[4] = '{64'd4, 64'd5, 1'b1, 0};
      vecs[5] = '{64'd1, 64'd3, 1'b0, 3};
      vecs[6] = '{64'd4, 64'd4, 1'b0, 16};
      vecs[7] = '{64'h1_0000_0002, 64'd1, 1'b1, 0};
      vecs[8] = '{64'd1, 64'h8000_0000_0000_0003, 1'b1, 0};

      bus.start         = 1'b0;
      bus.write_enable  = 1'b0;
      bus.write_index_i = '0;
      bus.write_index_j = '0;
      bus.write_data    = '0;
      bus.size_i_in     = '0;
      bus.size_j_in     = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("reset outputs",
            {bus.ready, bus.size_error, bus.data_out_i_enable, bus.data_out_j_enable, bus.data_out}, '0);

      for (int i = 0; i < SI; i++)
         for (int j = 0; j < SJ; j++)
            write_word(i, j, 64'h100 + 64'(i * SJ + j));
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 3; j++)
            write_word(i, j, 64'(i * 3 + j + 1));

      for (int v = 0; v < 9; v++)
         run_stream(vecs[v].si, vecs[v].sj, vecs[v].err, vecs[v].n, 0, 1, $sformatf("vec%0d", v));

      write_word(0, 0, 64'hDEAD);
      run_stream(64'd1, 64'd1, 1'b0, 1, 0, 1, "one_by_one");

      write_word(0, 0, 64'h11);
      run_stream(64'd4, 64'd4, 1'b0, 16, 1, 1, "midstream_ignored");
      write_word(0, 0, 64'h99);
      run_stream(64'd2, 64'd2, 1'b0, 4, 0, 1, "after_write");

      run_stream(64'd4, 64'd4, 1'b0, 16, 2, 1, "reset_abort");
      run_stream(64'd4, 64'd4, 1'b0, 16, 0, 1, "rerun");

      run_stream(64'd2, 64'd3, 1'b0, 6, 0, 2, "back_to_back");

      // Write and start in the same idle cycle: the new word must be sent.
      bus.write_enable  = 1'b1;
      bus.write_index_i = 2'd0;
      bus.write_index_j = 2'd0;
      bus.write_data    = 64'h1234;
      mem[0][0]         = 64'h1234;
      run_stream(64'd1, 64'd2, 1'b0, 2, 0, 1, "write_with_start");

      for (int it = 0; it < 25; it++) begin
         for (int w = 0; w < int'($urandom_range(1, 4)); w++)
            write_word(int'($urandom_range(0, SI - 1)), int'($urandom_range(0, SJ - 1)),
                       {$urandom, $urandom});
         rsi  = 64'($urandom_range(0, 5));
         rsj  = 64'($urandom_range(0, 5));
         rerr = (rsi == 0) || (rsj == 0) || (rsi > SI) || (rsj > SJ);
         run_stream(rsi, rsj, rerr, rerr ? 0 : int'(rsi * rsj), 0, 1, $sformatf("rand%0d", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
